// File: rtl/sram_pipe.sv
// Single-port word SRAM with byte-write enables, LAT-cycle read pipeline and a
// response FIFO; the request side is throttled so the FIFO never overflows.
module sram_pipe #(
  parameter int DW  = 32,
  parameter int AW  = 15,
  parameter int LAT = 1
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [AW-1:0]     REQ_A,
  input  logic [DW/8-1:0]   REQ_BYTE,
  input  logic [DW-1:0]     REQ_DI,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DW-1:0]     RSP_DO
);

  localparam int unsigned NB    = DW / 8;
  localparam int unsigned DEPTH = LAT + 1;
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [2**AW];

  logic          req_fire;
  logic          wr_fire;
  logic          rd_fire;
  logic          push;
  logic          pop;

  logic [LAT:1]  pv;
  logic [DW-1:0] pd [1:LAT];

  logic [DW-1:0] fifo [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] fcnt;

  logic [CW-1:0] occ;
  logic [CW-1:0] occ_nxt;

  // Reset outranks any handshake on the same edge.
  assign req_fire = REQ_VALID && REQ_READY && !RST;
  assign wr_fire  = req_fire && REQ_WE;
  assign rd_fire  = req_fire && !REQ_WE;
  assign push     = pv[LAT];
  assign pop      = RSP_VALID && RSP_READY;

  assign RSP_VALID = (fcnt != '0);
  assign RSP_DO    = fifo[rp];

  // Memory has no reset so contents survive RST.
  always_ff @(posedge CK) begin
    if (wr_fire) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (REQ_BYTE[b]) mem[REQ_A][8*b +: 8] <= REQ_DI[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CK) begin
    if (rd_fire) pd[1] <= mem[REQ_A];
    for (int unsigned i = 2; i <= LAT; i++) pd[i] <= pd[i-1];
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      pv <= '0;
    end else begin
      pv[1] <= rd_fire;
      for (int unsigned i = 2; i <= LAT; i++) pv[i] <= pv[i-1];
    end
  end

  always_ff @(posedge CK) begin
    if (!RST && push) fifo[wp] <= pd[LAT];
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else begin
      if (push) wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
      if (pop)  rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
      if (push && !pop)      fcnt <= fcnt + 1'b1;
      else if (!push && pop) fcnt <= fcnt - 1'b1;
    end
  end

  always_comb begin
    occ_nxt = occ;
    if (rd_fire && !pop)      occ_nxt = occ + 1'b1;
    else if (!rd_fire && pop) occ_nxt = occ - 1'b1;
  end

  // Ready is registered from the post-edge occupancy, so a full pipe+FIFO
  // blocks the very next request without a combinational path to REQ_VALID.
  always_ff @(posedge CK) begin
    if (RST) begin
      occ       <= '0;
      REQ_READY <= 1'b0;
    end else begin
      occ       <= occ_nxt;
      REQ_READY <= (occ_nxt < CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_sram_pipe.sv
// Directed self-checking bench for sram_pipe: three instances cover LAT=1,
// LAT=2 back-pressure, and a 64-bit narrow-address wrap configuration.
module tb_sram_pipe;

  logic CK = 1'b0;
  logic RST;
  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;

  // u0: DW=32 AW=15 LAT=1
  logic        a_valid, a_ready, a_we, a_rvalid, a_rready;
  logic [14:0] a_a;
  logic [3:0]  a_byte;
  logic [31:0] a_di, a_do;

  // u1: DW=32 AW=4 LAT=2
  logic        b_valid, b_ready, b_we, b_rvalid, b_rready;
  logic [3:0]  b_a;
  logic [3:0]  b_byte;
  logic [31:0] b_di, b_do;

  // u2: DW=64 AW=4 LAT=1
  logic        c_valid, c_ready, c_we, c_rvalid, c_rready;
  logic [3:0]  c_a;
  logic [7:0]  c_byte;
  logic [63:0] c_di, c_do;

  sram_pipe #(.DW(32), .AW(15), .LAT(1)) u0 (
    .CK(CK), .RST(RST), .REQ_VALID(a_valid), .REQ_READY(a_ready), .REQ_WE(a_we),
    .REQ_A(a_a), .REQ_BYTE(a_byte), .REQ_DI(a_di), .RSP_VALID(a_rvalid),
    .RSP_READY(a_rready), .RSP_DO(a_do));

  sram_pipe #(.DW(32), .AW(4), .LAT(2)) u1 (
    .CK(CK), .RST(RST), .REQ_VALID(b_valid), .REQ_READY(b_ready), .REQ_WE(b_we),
    .REQ_A(b_a), .REQ_BYTE(b_byte), .REQ_DI(b_di), .RSP_VALID(b_rvalid),
    .RSP_READY(b_rready), .RSP_DO(b_do));

  sram_pipe #(.DW(64), .AW(4), .LAT(1)) u2 (
    .CK(CK), .RST(RST), .REQ_VALID(c_valid), .REQ_READY(c_ready), .REQ_WE(c_we),
    .REQ_A(c_a), .REQ_BYTE(c_byte), .REQ_DI(c_di), .RSP_VALID(c_rvalid),
    .RSP_READY(c_rready), .RSP_DO(c_do));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All u0 tasks start and end on a falling edge.
  task automatic a_write(input logic [14:0] ad, input logic [3:0] be, input logic [31:0] d);
    a_valid = 1'b1; a_we = 1'b1; a_a = ad; a_byte = be; a_di = d;
    @(negedge CK);
    a_valid = 1'b0; a_we = 1'b0;
  endtask

  task automatic a_read(input string tag, input logic [14:0] ad, input logic [31:0] exp);
    a_valid = 1'b1; a_we = 1'b0; a_a = ad;
    @(negedge CK);
    a_valid = 1'b0;
    check({tag, "_v1"}, a_rvalid, 1'b0);
    @(negedge CK);
    check({tag, "_v2"}, a_rvalid, 1'b1);
    check({tag, "_do"}, a_do, exp);
  endtask

  task automatic b_write(input logic [3:0] ad, input logic [31:0] d);
    b_valid = 1'b1; b_we = 1'b1; b_a = ad; b_byte = 4'hF; b_di = d;
    @(negedge CK);
    b_valid = 1'b0; b_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    int wrap_addr;
    RST = 1'b1;
    a_valid = 0; a_we = 0; a_a = '0; a_byte = '0; a_di = '0; a_rready = 1'b1;
    b_valid = 0; b_we = 0; b_a = '0; b_byte = '0; b_di = '0; b_rready = 1'b1;
    c_valid = 0; c_we = 0; c_a = '0; c_byte = '0; c_di = '0; c_rready = 1'b1;

    repeat (3) @(negedge CK);
    check("rst_ready", a_ready, 1'b0);
    check("rst_rvalid", a_rvalid, 1'b0);
    RST = 1'b0;
    @(negedge CK);
    check("post_rst_ready", a_ready, 1'b1);
    check("post_rst_ready_b", b_ready, 1'b1);

    // Basic write/read, latency 2 cycles to RSP_VALID
    a_write(15'd5, 4'hF, 32'hA5A5_1234);
    a_read("rd5", 15'd5, 32'hA5A5_1234);
    @(negedge CK);
    check("rd5_popped", a_rvalid, 1'b0);

    // Byte enables
    a_write(15'd7, 4'hF, 32'h1122_3344);
    a_write(15'd7, 4'b0101, 32'hFFFF_FFFF);
    a_read("rd7", 15'd7, 32'h11FF_33FF);
    a_write(15'd7, 4'h0, 32'h0000_0000);
    a_read("rd7_be0", 15'd7, 32'h11FF_33FF);

    // Write then read same address back-to-back
    a_write(15'd9, 4'hF, 32'h0000_0000);
    a_write(15'd9, 4'hF, 32'hDEAD_BEEF);
    a_read("rd9_b2b", 15'd9, 32'hDEAD_BEEF);

    // Inputs ignored while REQ_VALID=0
    a_valid = 1'b0; a_we = 1'b1; a_a = 15'd5; a_byte = 4'hF; a_di = 32'h0;
    @(negedge CK);
    a_we = 1'b0;
    a_read("rd5_novalid", 15'd5, 32'hA5A5_1234);

    // Reset one cycle after a read accept aborts it
    @(negedge CK);
    a_valid = 1'b1; a_we = 1'b0; a_a = 15'd5;
    @(negedge CK);
    a_valid = 1'b0;
    RST = 1'b1;
    @(negedge CK);
    check("abort_rvalid_rst", a_rvalid, 1'b0);
    check("abort_ready_rst", a_ready, 1'b0);
    RST = 1'b0;
    @(negedge CK);
    check("abort_ready_after", a_ready, 1'b1);
    check("abort_rvalid_after", a_rvalid, 1'b0);
    repeat (3) @(negedge CK);
    check("abort_no_rsp", a_rvalid, 1'b0);
    a_read("rd5_after_rst", 15'd5, 32'hA5A5_1234);
    @(negedge CK);

    // LAT=2 back-pressure: three reads fill pipe + FIFO
    for (int i = 0; i < 4; i++) b_write(4'(i), 32'h100 + i);
    b_rready = 1'b0;
    b_valid = 1'b1; b_we = 1'b0; b_a = 4'd0;
    check("bp_ready0", b_ready, 1'b1);
    @(negedge CK);
    b_a = 4'd1;
    check("bp_ready1", b_ready, 1'b1);
    @(negedge CK);
    b_a = 4'd2;
    check("bp_ready2", b_ready, 1'b1);
    @(negedge CK);
    b_a = 4'd3;
    check("bp_full", b_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CK);
      check("bp_hold", b_ready, 1'b0);
    end
    check("bp_head_v", b_rvalid, 1'b1);
    check("bp_head0", b_do, 32'h100);
    @(negedge CK);
    check("bp_stable", b_do, 32'h100);
    b_rready = 1'b1;
    @(negedge CK);
    check("bp_head1", b_do, 32'h101);
    check("bp_reopen", b_ready, 1'b1);
    @(negedge CK);
    b_valid = 1'b0;
    check("bp_head2", b_do, 32'h102);
    @(negedge CK);
    check("bp_gap", b_rvalid, 1'b0);
    @(negedge CK);
    check("bp_r3_v", b_rvalid, 1'b1);
    check("bp_r3", b_do, 32'h103);
    @(negedge CK);

    // DW=64 AW=4 address wrap: 31 mod 16 = 15
    c_valid = 1'b1; c_we = 1'b1; c_a = 4'd15; c_byte = 8'hFF; c_di = 64'h0123_4567_89AB_CDEF;
    @(negedge CK);
    wrap_addr = 31;
    c_we = 1'b0; c_a = wrap_addr[3:0];
    @(negedge CK);
    c_valid = 1'b0;
    @(negedge CK);
    check("wrap_v", c_rvalid, 1'b1);
    check("wrap_do", c_do, 64'h0123_4567_89AB_CDEF);
    @(negedge CK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
